// File: rtl/cellrv32_npu_instruction_dispatcher.sv
// NPU instruction dispatcher: pops instructions from the instruction FIFO and issues
// them to the weight-loader, matrix-multiply and activation units under busy/dependency rules.
module cellrv32_npu_instruction_dispatcher #(
    parameter int unsigned INST_WIDTH = 80,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  enable_i,
    input  logic [INST_WIDTH-1:0] fifo_inst_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_nxt_en_o,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic                  wl_en_o,
    output logic                  mm_en_o,
    output logic                  act_en_o,
    input  logic                  wl_busy_i,
    input  logic                  mm_busy_i,
    input  logic                  act_busy_i,
    output logic                  sync_done_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [CNT_WIDTH-1:0]  count_o
);

    localparam int unsigned CLS_WIDTH = 3;

    localparam logic [CLS_WIDTH-1:0] CLS_NOP  = 3'b000;
    localparam logic [CLS_WIDTH-1:0] CLS_WL   = 3'b001;
    localparam logic [CLS_WIDTH-1:0] CLS_MM   = 3'b010;
    localparam logic [CLS_WIDTH-1:0] CLS_ACT  = 3'b100;
    localparam logic [CLS_WIDTH-1:0] CLS_SYNC = 3'b111;

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_SYNC_WAIT
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [INST_WIDTH-1:0]   inst_q;
    logic [INST_WIDTH-1:0]   inst_last_q;
    logic [2:0]              pend_q;
    logic [CNT_WIDTH-1:0]    count_q;
    logic                    err_q;

    logic                    pop_c;
    logic                    wl_go_c;
    logic                    mm_go_c;
    logic                    act_go_c;
    logic                    sync_go_c;
    logic                    retire_c;
    logic                    illegal_c;
    logic                    issue_c;
    logic                    wl_free_c;
    logic                    mm_free_c;
    logic                    act_free_c;
    logic [CLS_WIDTH-1:0]    cls_c;

    // Class field is the top three bits of the opcode byte.
    assign cls_c      = inst_q[INST_WIDTH-1 -: CLS_WIDTH];
    assign wl_free_c  = !wl_busy_i  && !pend_q[0];
    assign mm_free_c  = !mm_busy_i  && !pend_q[1];
    assign act_free_c = !act_busy_i && !pend_q[2];
    assign issue_c    = wl_go_c | mm_go_c | act_go_c;

    // Next-state and strobe decode; nothing fires while reset is asserted.
    always_comb begin
        state_d   = state_q;
        pop_c     = 1'b0;
        wl_go_c   = 1'b0;
        mm_go_c   = 1'b0;
        act_go_c  = 1'b0;
        sync_go_c = 1'b0;
        retire_c  = 1'b0;
        illegal_c = 1'b0;
        if (rstn_i) begin
            case (state_q)
                S_FETCH: begin
                    if (enable_i && !fifo_empty_i) begin
                        pop_c   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (cls_c)
                        CLS_NOP: begin
                            retire_c = 1'b1;
                            state_d  = S_FETCH;
                        end
                        CLS_WL, CLS_MM, CLS_ACT: state_d = S_ISSUE;
                        CLS_SYNC: state_d = S_SYNC_WAIT;
                        default: begin
                            illegal_c = 1'b1;
                            state_d   = S_FETCH;
                        end
                    endcase
                end
                S_ISSUE: begin
                    case (cls_c)
                        CLS_WL:  wl_go_c  = wl_free_c;
                        CLS_MM:  mm_go_c  = mm_free_c && wl_free_c;
                        CLS_ACT: act_go_c = act_free_c && mm_free_c;
                        default: state_d  = S_FETCH;
                    endcase
                    if (wl_go_c || mm_go_c || act_go_c) begin
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
                S_SYNC_WAIT: begin
                    if (wl_free_c && mm_free_c && act_free_c) begin
                        sync_go_c = 1'b1;
                        retire_c  = 1'b1;
                        state_d   = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // State, latched instruction, pending guards, counter and error flag.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= S_FETCH;
            inst_q      <= '0;
            inst_last_q <= '0;
            pend_q      <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop_c) begin
                inst_q <= fifo_inst_i;
            end
            if (issue_c) begin
                inst_last_q <= inst_q;
            end
            pend_q <= {act_go_c, mm_go_c, wl_go_c};
            if (retire_c) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end
            if (illegal_c) begin
                err_q <= 1'b1;
            end
        end
    end

    // inst_o shows the issuing instruction in the pulse cycle and holds it afterwards.
    assign inst_o        = issue_c ? inst_q : inst_last_q;
    assign fifo_nxt_en_o = pop_c;
    assign wl_en_o       = wl_go_c;
    assign mm_en_o       = mm_go_c;
    assign act_en_o      = act_go_c;
    assign sync_done_o   = sync_go_c;
    assign err_o         = err_q;
    assign count_o       = count_q;
    assign busy_o        = rstn_i & ((state_q != S_FETCH) | wl_busy_i | mm_busy_i
                                     | act_busy_i | (|pend_q));

endmodule

// File: tb/tb_cellrv32_npu_instruction_dispatcher.sv
// Directed self-checking bench for the NPU instruction dispatcher.
module tb_cellrv32_npu_instruction_dispatcher;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [79:0] fifo_inst;
    logic        fifo_empty;
    logic        fifo_nxt_en;
    logic [79:0] inst_out;
    logic        wl_en;
    logic        mm_en;
    logic        act_en;
    logic        wl_busy;
    logic        mm_busy;
    logic        act_busy;
    logic        sync_done;
    logic        busy;
    logic        err;
    logic [15:0] count;

    int errors = 0;
    int checks = 0;

    // Show-ahead FIFO model feeding the dispatcher.
    logic [79:0] fifo_mem [16];
    logic [3:0]  head = 4'd0;
    logic [3:0]  tail = 4'd0;

    assign fifo_empty = (head == tail);
    assign fifo_inst  = fifo_mem[head];

    always @(posedge clk) begin
        if (fifo_nxt_en) head <= head + 4'd1;
    end

    always #5 clk = ~clk;

    cellrv32_npu_instruction_dispatcher #(
        .INST_WIDTH (80),
        .CNT_WIDTH  (16)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .enable_i      (enable),
        .fifo_inst_i   (fifo_inst),
        .fifo_empty_i  (fifo_empty),
        .fifo_nxt_en_o (fifo_nxt_en),
        .inst_o        (inst_out),
        .wl_en_o       (wl_en),
        .mm_en_o       (mm_en),
        .act_en_o      (act_en),
        .wl_busy_i     (wl_busy),
        .mm_busy_i     (mm_busy),
        .act_busy_i    (act_busy),
        .sync_done_o   (sync_done),
        .busy_o        (busy),
        .err_o         (err),
        .count_o       (count)
    );

    task automatic push(input logic [79:0] x);
        fifo_mem[tail] = x;
        tail = tail + 4'd1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [79:0] i_a = 80'h20_1111_2222_3333_4444_01;
    logic [79:0] i_b = 80'h40_1111_2222_3333_4444_02;
    logic [79:0] i_n = 80'h00_1111_2222_3333_4444_03;
    logic [79:0] i_x = 80'h60_1111_2222_3333_4444_04;
    logic [79:0] i_c = 80'h20_1111_2222_3333_4444_05;
    logic [79:0] i_d = 80'h20_1111_2222_3333_4444_06;
    logic [79:0] i_e = 80'h80_1111_2222_3333_4444_07;
    logic [79:0] i_f = 80'hE0_1111_2222_3333_4444_08;
    logic [79:0] i_g = 80'h20_1111_2222_3333_4444_09;
    logic [79:0] i_h = 80'h20_1111_2222_3333_4444_0A;
    logic [79:0] i_i = 80'h20_1111_2222_3333_4444_0B;
    logic [79:0] i_j = 80'h40_1111_2222_3333_4444_0C;

    logic [7:0]  t3_nxt = 8'b0001_0101;
    logic [7:0]  t3_wl  = 8'b0100_0000;
    logic [7:0]  t3_err = 8'b1111_0000;
    int          t3_cnt [8] = '{2, 2, 3, 3, 3, 3, 3, 4};
    logic [15:0] t4_nxt  = 16'h1049;
    logic [15:0] t4_wl   = 16'h4004;
    logic [15:0] t4_act  = 16'h0020;
    logic [15:0] t4_sync = 16'h0800;
    logic [6:0]  t5_wl  = 7'b010_0100;
    logic [6:0]  t5_nxt = 7'b000_1001;

    initial begin
        rstn     = 1'b0;
        enable   = 1'b0;
        wl_busy  = 1'b0;
        mm_busy  = 1'b0;
        act_busy = 1'b0;
        repeat (3) step();
        #1;
        chk("rst_count", 80'(count), 80'd0);
        chk("rst_err", 80'(err), 80'd0);
        chk("rst_inst", inst_out, 80'd0);
        chk("rst_strobes", 80'({fifo_nxt_en, wl_en, mm_en, act_en, sync_done, busy}), 80'd0);

        // Single WL: pop at c0, issue at c2.
        step();
        rstn = 1'b1;
        enable = 1'b1;
        push(i_a);
        #1;
        chk("t1_pop_c0", 80'(fifo_nxt_en), 80'd1);
        chk("t1_wl_c0", 80'(wl_en), 80'd0);
        step(); #1;
        chk("t1_pop_c1", 80'(fifo_nxt_en), 80'd0);
        chk("t1_busy_c1", 80'(busy), 80'd1);
        chk("t1_wl_c1", 80'(wl_en), 80'd0);
        step(); #1;
        chk("t1_wl_c2", 80'(wl_en), 80'd1);
        chk("t1_inst_c2", inst_out, i_a);
        chk("t1_mmact_c2", 80'({mm_en, act_en}), 80'd0);
        step(); #1;
        chk("t1_wl_c3", 80'(wl_en), 80'd0);
        chk("t1_cnt_c3", 80'(count), 80'd1);
        chk("t1_hold_c3", inst_out, i_a);
        chk("t1_pend_busy_c3", 80'(busy), 80'd1);
        step(); #1;
        chk("t1_idle_c4", 80'(busy), 80'd0);

        // MM waits for WL busy to drop.
        step();
        wl_busy = 1'b1;
        push(i_b);
        #1;
        chk("t2_pop", 80'(fifo_nxt_en), 80'd1);
        for (int k = 1; k < 10; k++) begin
            step(); #1;
            chk("t2_mm_held", 80'(mm_en), 80'd0);
        end
        chk("t2_busy_wait", 80'(busy), 80'd1);
        step();
        wl_busy = 1'b0;
        #1;
        chk("t2_mm_issue", 80'(mm_en), 80'd1);
        chk("t2_inst", inst_out, i_b);
        step(); #1;
        chk("t2_mm_once", 80'(mm_en), 80'd0);
        chk("t2_cnt", 80'(count), 80'd2);

        // NOP, illegal, WL back to back.
        for (int c = 0; c < 8; c++) begin
            step();
            if (c == 0) begin
                push(i_n);
                push(i_x);
                push(i_c);
            end
            #1;
            chk("t3_pop", 80'(fifo_nxt_en), 80'(t3_nxt[c]));
            chk("t3_wl", 80'(wl_en), 80'(t3_wl[c]));
            chk("t3_err", 80'(err), 80'(t3_err[c]));
            chk("t3_cnt", 80'(count), 80'(t3_cnt[c]));
            chk("t3_other_en", 80'({mm_en, act_en, sync_done}), 80'd0);
            if (c == 6) chk("t3_inst", inst_out, i_c);
        end

        // WL, ACT, SYNC behind ACT busy, then WL after the barrier.
        for (int c = 0; c < 16; c++) begin
            step();
            if (c == 0) begin
                push(i_d);
                push(i_e);
                push(i_f);
                push(i_g);
            end
            act_busy = (c >= 6 && c <= 10);
            #1;
            chk("t4_pop", 80'(fifo_nxt_en), 80'(t4_nxt[c]));
            chk("t4_wl", 80'(wl_en), 80'(t4_wl[c]));
            chk("t4_act", 80'(act_en), 80'(t4_act[c]));
            chk("t4_sync", 80'(sync_done), 80'(t4_sync[c]));
            chk("t4_mm", 80'(mm_en), 80'd0);
            if (c == 5) chk("t4_inst_act", inst_out, i_e);
        end
        chk("t4_cnt", 80'(count), 80'd8);
        chk("t4_err_sticky", 80'(err), 80'd1);

        // Two WL to a unit that never raises busy.
        for (int c = 0; c < 7; c++) begin
            step();
            if (c == 0) begin
                push(i_h);
                push(i_i);
            end
            #1;
            chk("t5_wl", 80'(wl_en), 80'(t5_wl[c]));
            chk("t5_pop", 80'(fifo_nxt_en), 80'(t5_nxt[c]));
        end
        chk("t5_inst_hold", inst_out, i_i);
        chk("t5_cnt", 80'(count), 80'd10);

        // Reset while MM waits in ISSUE.
        step();
        mm_busy = 1'b1;
        push(i_j);
        #1;
        chk("t6_pop", 80'(fifo_nxt_en), 80'd1);
        step(); #1;
        step(); #1;
        chk("t6_wait", 80'(mm_en), 80'd0);
        chk("t6_busy", 80'(busy), 80'd1);
        step();
        rstn = 1'b0;
        #1;
        chk("t6_rst_mm", 80'(mm_en), 80'd0);
        step(); #1;
        chk("t6_cnt", 80'(count), 80'd0);
        chk("t6_err", 80'(err), 80'd0);
        chk("t6_inst", inst_out, 80'd0);
        chk("t6_strobes", 80'({fifo_nxt_en, wl_en, mm_en, act_en, sync_done, busy}), 80'd0);
        step();
        rstn = 1'b1;
        #1;
        chk("t6_busy_seen", 80'(busy), 80'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            mm_busy = 1'b0;
            #1;
            chk("t6_no_issue", 80'({mm_en, fifo_nxt_en}), 80'd0);
        end
        chk("t6_idle", 80'(busy), 80'd0);
        chk("t6_cnt_end", 80'(count), 80'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
